// File: rtl/pipe_mon_pkg.sv
// Shared types and defaults for the pipeline retire monitor.
//   mon_state_e  : monitor FSM state (2-bit)
//   commit_rec_t : commit record {rd, data} carried through the commit FIFO
package pipe_mon_pkg;

  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_IDLE_LIMIT = 4;
  localparam int unsigned DEF_CNT_W      = 16;

  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } commit_rec_t;

endpackage

// File: rtl/commit_fifo.sv
// Commit-record FIFO with valid/ready read side and sticky drop flag.
//   clk, rst_n : clock, async active-low reset
//   en         : global update enable (low until reset release is synchronised)
//   push       : write push_rec this cycle
//   pop_ready  : consumer accepts head record
//   valid_c    : head record available (combinational from pointers)
//   head_c     : head record, zero while empty
//   overflow   : sticky, a push was dropped on a full FIFO
module commit_fifo
  import pipe_mon_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        push,
  input  commit_rec_t push_rec,
  input  logic        pop_ready,
  output logic        valid_c,
  output commit_rec_t head_c,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Extra MSB on each pointer separates full from empty.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  commit_rec_t   mem [DEPTH];
  logic          empty_c;
  logic          full_c;
  logic          pop_c;
  logic          push_c;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside a pop.
  always_comb begin
    empty_c = (wr_ptr == rd_ptr);
    full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop_c   = en && !empty_c && pop_ready;
    push_c  = en && push && (!full_c || pop_c);
    valid_c = !empty_c;
    head_c  = empty_c ? '0 : mem[rd_ptr[AW-1:0]];
  end

  // Pointers and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      if (en && push && full_c && !pop_c) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr[AW-1:0]] <= push_rec;
  end

endmodule

// File: rtl/pipe_retire_monitor.sv
// Pipeline retire monitor: counts run cycles and retirements, queues register
// write-backs as commit records and declares end of program after a quiet period.
//   clk_i, rst_i                 : clock, async active-low reset
//   wb_valid_i/regwrite/rd/data  : write-back stage retirement
//   commit_valid/ready/rd/data   : commit record stream (FIFO head)
//   cycle_cnt_o, retired_cnt_o   : saturating counters
//   overflow_o                   : sticky, a commit record was dropped
//   done_o                       : end of program reached and FIFO drained
module pipe_retire_monitor
  import pipe_mon_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned IDLE_LIMIT = DEF_IDLE_LIMIT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wb_valid_i,
  input  logic             wb_regwrite_i,
  input  logic [4:0]       wb_rd_i,
  input  logic [31:0]      wb_data_i,
  output logic             commit_valid_o,
  input  logic             commit_ready_i,
  output logic [4:0]       commit_rd_o,
  output logic [31:0]      commit_data_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] retired_cnt_o,
  output logic             overflow_o,
  output logic             done_o
);

  localparam int unsigned       IDLE_W    = $clog2(IDLE_LIMIT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);

  mon_state_e        state_q;
  mon_state_e        state_d;
  logic              active_q;
  logic [IDLE_W-1:0] idle_q;
  logic              retire_c;
  logic              push_c;
  logic              count_cycle_c;
  logic              idle_clr_c;
  commit_rec_t       push_rec_c;
  commit_rec_t       head_c;

  // Reset release is taken through one flop; nothing updates until it is set.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) active_q <= 1'b0;
    else        active_q <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)        state_q <= ST_IDLE;
    else if (active_q) state_q <= state_d;
  end

  // Next state; a retirement in DRAIN wins over the empty-FIFO exit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (wb_valid_i) state_d = ST_RUN;
      ST_RUN:   if (!wb_valid_i && idle_q == IDLE_LAST) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (wb_valid_i)          state_d = ST_RUN;
        else if (!commit_valid_o) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Per-state controls; DONE ignores the write-back port entirely.
  always_comb begin
    retire_c      = 1'b0;
    count_cycle_c = 1'b0;
    idle_clr_c    = 1'b1;
    case (state_q)
      ST_IDLE:  retire_c = wb_valid_i;
      ST_RUN: begin
        retire_c      = wb_valid_i;
        count_cycle_c = 1'b1;
        idle_clr_c    = wb_valid_i;
      end
      ST_DRAIN: begin
        retire_c      = wb_valid_i;
        count_cycle_c = 1'b1;
      end
      default: ;
    endcase
    push_c     = retire_c && wb_regwrite_i && (wb_rd_i != 5'd0);
    push_rec_c = commit_rec_t'{rd: wb_rd_i, data: wb_data_i};
  end

  // Idle counter, saturating statistics counters and registered done flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idle_q        <= '0;
      cycle_cnt_o   <= '0;
      retired_cnt_o <= '0;
      done_o        <= 1'b0;
    end else if (active_q) begin
      idle_q <= idle_clr_c ? '0 : idle_q + IDLE_W'(1);
      if (count_cycle_c && (cycle_cnt_o != '1))
        cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
      if (retire_c && (retired_cnt_o != '1))
        retired_cnt_o <= retired_cnt_o + CNT_W'(1);
      done_o <= (state_d == ST_DONE);
    end
  end

  commit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_commit_fifo (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .en        (active_q),
    .push      (push_c),
    .push_rec  (push_rec_c),
    .pop_ready (commit_ready_i),
    .valid_c   (commit_valid_o),
    .head_c    (head_c),
    .overflow  (overflow_o)
  );

  assign commit_rd_o   = head_c.rd;
  assign commit_data_o = head_c.data;

endmodule

// File: tb/tb_pipe_retire_monitor.sv
// Bench for pipe_retire_monitor: directed scenarios plus randomized episodes,
// checked by a cycle-level reference model and a commit-record scoreboard.
module tb_pipe_retire_monitor;

  localparam int DEPTH   = 4;
  localparam int LIMIT   = 4;
  localparam int CW      = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_DONE  = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          wb_valid_i = 1'b0;
  logic          wb_regwrite_i = 1'b0;
  logic [4:0]    wb_rd_i = '0;
  logic [31:0]   wb_data_i = '0;
  logic          commit_valid_o;
  logic          commit_ready_i = 1'b0;
  logic [4:0]    commit_rd_o;
  logic [31:0]   commit_data_o;
  logic [CW-1:0] cycle_cnt_o;
  logic [CW-1:0] retired_cnt_o;
  logic          overflow_o;
  logic          done_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (what the DUT should show after the latest edge).
  int  m_occ    = 0;
  int  m_phase  = PH_IDLE;
  int  m_idle   = 0;
  int  m_cyc    = 0;
  int  m_ret    = 0;
  bit  m_ovf    = 1'b0;
  bit  m_active = 1'b0;
  logic [36:0] exp_q[$];

  pipe_retire_monitor #(
    .FIFO_DEPTH (DEPTH),
    .IDLE_LIMIT (LIMIT),
    .CNT_W      (CW)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wb_valid_i     (wb_valid_i),
    .wb_regwrite_i  (wb_regwrite_i),
    .wb_rd_i        (wb_rd_i),
    .wb_data_i      (wb_data_i),
    .commit_valid_o (commit_valid_o),
    .commit_ready_i (commit_ready_i),
    .commit_rd_o    (commit_rd_o),
    .commit_data_o  (commit_data_o),
    .cycle_cnt_o    (cycle_cnt_o),
    .retired_cnt_o  (retired_cnt_o),
    .overflow_o     (overflow_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_occ    = 0;
    m_phase  = PH_IDLE;
    m_idle   = 0;
    m_cyc    = 0;
    m_ret    = 0;
    m_ovf    = 1'b0;
    m_active = 1'b0;
    exp_q.delete();
  endtask

  // Advance the model across one rising edge using the inputs held during the cycle.
  task automatic model_step();
    int occ0;
    bit pop;
    bit ret;
    bit push;
    if (!rst_i) begin
      model_reset();
      return;
    end
    if (!m_active) begin
      m_active = 1'b1;
      return;
    end
    occ0 = m_occ;
    pop  = (occ0 > 0) && commit_ready_i;
    ret  = wb_valid_i && (m_phase != PH_DONE);
    push = ret && wb_regwrite_i && (wb_rd_i != 5'd0);
    if ((m_phase == PH_RUN || m_phase == PH_DRAIN) && m_cyc < CNT_MAX) m_cyc++;
    if (ret && m_ret < CNT_MAX) m_ret++;
    if (push) begin
      if (occ0 < DEPTH || pop) begin
        exp_q.push_back({wb_rd_i, wb_data_i});
        m_occ++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (pop) m_occ--;
    case (m_phase)
      PH_IDLE: if (wb_valid_i) m_phase = PH_RUN;
      PH_RUN: begin
        if (wb_valid_i) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == LIMIT) begin
            m_phase = PH_DRAIN;
            m_idle  = 0;
          end
        end
      end
      PH_DRAIN: begin
        if (wb_valid_i) begin
          m_phase = PH_RUN;
          m_idle  = 0;
        end else if (occ0 == 0) m_phase = PH_DONE;
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic drive(input bit v, input bit rw, input logic [4:0] rd,
                       input logic [31:0] d, input bit rdy);
    wb_valid_i     = v;
    wb_regwrite_i  = rw;
    wb_rd_i        = rd;
    wb_data_i      = d;
    commit_ready_i = rdy;
    tick();
  endtask

  task automatic quiet(input int n, input bit rdy);
    repeat (n) drive(1'b0, 1'b0, 5'd0, 32'd0, rdy);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},   64'(commit_valid_o), 64'(0));
    check({tag, "_rd"},      64'(commit_rd_o),    64'(0));
    check({tag, "_data"},    64'(commit_data_o),  64'(0));
    check({tag, "_cycle"},   64'(cycle_cnt_o),    64'(0));
    check({tag, "_retired"}, 64'(retired_cnt_o),  64'(0));
    check({tag, "_ovf"},     64'(overflow_o),     64'(0));
    check({tag, "_done"},    64'(done_o),         64'(0));
  endtask

  // Reset asserted mid-cycle: outputs must clear at once, before any clock edge.
  task automatic do_reset(input string tag);
    rst_i          = 1'b0;
    wb_valid_i     = 1'b0;
    wb_regwrite_i  = 1'b0;
    wb_rd_i        = '0;
    wb_data_i      = '0;
    commit_ready_i = 1'b0;
    model_reset();
    #1;
    check_zero(tag);
    tick();
    tick();
    rst_i = 1'b1;
    tick();
  endtask

  // Monitor: compares DUT outputs to the model and pops the scoreboard on each handshake.
  always @(negedge clk_i) begin
    logic [36:0] e;
    check("commit_valid", 64'(commit_valid_o), 64'(m_occ > 0));
    if (commit_valid_o && commit_ready_i) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL commit_rec: got rd=%0d data=0x%0h, expected no record",
                 commit_rd_o, commit_data_o);
      end else begin
        e = exp_q.pop_front();
        check("commit_rec", 64'({commit_rd_o, commit_data_o}), 64'(e));
      end
    end
    check("cycle_cnt",   64'(cycle_cnt_o),   64'(m_cyc));
    check("retired_cnt", 64'(retired_cnt_o), 64'(m_ret));
    check("overflow",    64'(overflow_o),    64'(m_ovf));
    check("done",        64'(done_o),        64'(m_phase == PH_DONE));
  end

  initial begin
    int n;
    int p;
    int q;
    model_reset();

    // Two retirements with a ready consumer.
    do_reset("rst0");
    drive(1, 1, 5'd8, 32'h5, 1);
    drive(1, 1, 5'd9, 32'hA, 1);
    quiet(2, 1);
    check("seq_retired", 64'(retired_cnt_o), 64'(2));

    // r0 write and a store retire without producing records.
    do_reset("rst1");
    drive(1, 1, 5'd0, 32'h1234, 1);
    drive(1, 0, 5'd3, 32'h55, 1);
    quiet(1, 1);
    check("norec_valid",   64'(commit_valid_o), 64'(0));
    check("norec_retired", 64'(retired_cnt_o),  64'(2));

    // Fifth record into a stalled full FIFO is dropped.
    do_reset("rst2");
    for (int i = 1; i <= 5; i++) drive(1, 1, 5'(i), 32'(i * 100), 0);
    check("full_ovf", 64'(overflow_o), 64'(1));
    quiet(6, 1);
    check("full_ovf_sticky", 64'(overflow_o), 64'(1));

    // End of program: 3 retirements then silence.
    do_reset("rst3");
    for (int i = 0; i < 3; i++) drive(1, 1, 5'(i + 1), 32'(i), 1);
    n = 0;
    while (!done_o && n < 20) begin
      quiet(1, 1);
      n++;
    end
    check("eop_quiet_cycles", 64'(n), 64'(5));
    check("eop_done",         64'(done_o), 64'(1));
    check("eop_cycle_cnt",    64'(cycle_cnt_o), 64'(7));
    drive(1, 1, 5'd7, 32'hDEAD, 1);
    quiet(1, 1);
    check("eop_ignored", 64'(retired_cnt_o), 64'(3));

    // Retirement during DRAIN returns to RUN with the idle count restarted.
    do_reset("rst4");
    drive(1, 1, 5'd1, 32'h11, 0);
    drive(1, 1, 5'd2, 32'h22, 0);
    quiet(5, 0);
    drive(1, 1, 5'd3, 32'h33, 0);
    quiet(3, 0);
    check("drain_rerun_done", 64'(done_o), 64'(0));
    quiet(10, 1);
    check("drain_final_done", 64'(done_o), 64'(1));

    // Reset in the middle of RUN with records queued.
    do_reset("rst5");
    for (int i = 0; i < 3; i++) drive(1, 1, 5'(i + 4), 32'(i + 40), 0);
    do_reset("midrun");
    quiet(1, 1);
    check("post_rst_valid", 64'(commit_valid_o), 64'(0));

    // Randomized episodes with varying retire and ready densities.
    for (int ep = 0; ep < 8; ep++) begin
      do_reset("rnd");
      p = (ep % 4 == 0) ? 15 : (ep % 4 == 1) ? 45 : (ep % 4 == 2) ? 75 : 95;
      q = (ep % 2 == 0) ? 40 : 90;
      for (int c = 0; c < 150; c++) begin
        if (ep == 5 && c == 70) do_reset("rnd_mid");
        drive(32'($urandom % 100) < p,
              ($urandom % 4) != 0,
              5'($urandom_range(0, 7)),
              $urandom,
              32'($urandom % 100) < q);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
